// File: rtl/mem_block_copier_pkg.sv
// Shared definitions for the memory block copier: FSM state encoding and
// operation-mode constants.
package mem_block_copier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_copier.sv
// Word-wise block copy / fill engine driving a single-port data memory with
// combinational read data. Copy alternates RD/WR per word; fill issues WR only.
module mem_block_copier
    import mem_block_copier_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic              wr_en_mem,
    output logic [ADDR_W-1:0] add_mem,
    output logic [DATA_W-1:0] wrd_mem,
    input  logic [DATA_W-1:0] rdd_mem
);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   src_ptr;
    logic [ADDR_W-1:0]   dst_ptr;
    logic [LEN_W-1:0]    remaining;
    logic [DATA_W-1:0]   data_reg;
    logic [DATA_W-1:0]   fill_reg;
    logic                mode_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            words_done <= '0;
            data_reg   <= '0;
            fill_reg   <= '0;
            mode_reg   <= MODE_COPY;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // Any accepted start (including len=0) resets the word count.
                    if (start) begin
                        words_done <= '0;
                        if (len != '0) begin
                            src_ptr   <= src_addr;
                            dst_ptr   <= dst_addr;
                            remaining <= len;
                            mode_reg  <= mode;
                            fill_reg  <= fill_value;
                        end
                    end
                end
                RD: begin
                    data_reg <= rdd_mem;
                end
                WR: begin
                    src_ptr    <= src_ptr + ADDR_W'(1);
                    dst_ptr    <= dst_ptr + ADDR_W'(1);
                    remaining  <= remaining - LEN_W'(1);
                    words_done <= words_done + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        wr_en_mem  = 1'b0;
        add_mem    = '0;
        wrd_mem    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_next = DONE;
                    else if (mode == MODE_FILL)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                add_mem    = src_ptr;
                state_next = WR;
            end
            WR: begin
                busy      = 1'b1;
                // Gate with rst so a reset landing on a write cycle never commits it.
                wr_en_mem = ~rst;
                add_mem   = dst_ptr;
                wrd_mem   = (mode_reg == MODE_FILL) ? fill_reg : data_reg;
                if (remaining == LEN_W'(1))
                    state_next = DONE;
                else if (mode_reg == MODE_FILL)
                    state_next = WR;
                else
                    state_next = RD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_block_copier.sv
// Self-checking bench for mem_block_copier with a 256-word memory model and
// a write scoreboard (expected writes queued at stimulus, compared on drain).
module tb_mem_block_copier;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 9;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic [DW-1:0] fill_value = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_done;
    logic          wr_en_mem;
    logic [AW-1:0] add_mem;
    logic [DW-1:0] wrd_mem;
    logic [DW-1:0] rdd_mem;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] exp_mem [256];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  checks = 0;
    int  errors = 0;

    mem_block_copier #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_value(fill_value), .busy(busy), .done(done),
        .words_done(words_done), .wr_en_mem(wr_en_mem), .add_mem(add_mem),
        .wrd_mem(wrd_mem), .rdd_mem(rdd_mem)
    );

    always #5 clk = ~clk;

    assign rdd_mem = mem[add_mem[7:0]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (wr_en_mem)
            mem[add_mem[7:0]] <= wrd_mem;
    end

    task automatic tick();
        @(negedge clk);
        if (wr_en_mem === 1'b1)
            obs_q.push_back({add_mem, wrd_mem});
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a[7:0];
        pl_data = d;
        exp_mem[a[7:0]] = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic model_xfer(input logic m, input logic [AW-1:0] s,
                              input logic [AW-1:0] dd, input int n,
                              input logic [DW-1:0] f);
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            sa = s + AW'(i);
            da = dd + AW'(i);
            v  = m ? f : exp_mem[sa[7:0]];
            exp_mem[da[7:0]] = v;
            exp_q.push_back({da, v});
        end
    endtask

    task automatic kick(input logic m, input logic [AW-1:0] s,
                        input logic [AW-1:0] dd, input int n,
                        input logic [DW-1:0] f);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = dd; len = LW'(n); fill_value = f;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, wr_en_mem} !== 3'b000 || words_done !== '0 ||
            add_mem !== '0 || wrd_mem !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b wd=%0d addr=%h data=%h, required all zero",
                     busy, done, wr_en_mem, words_done, add_mem, wrd_mem);
        end
        for (int i = 0; i < 256; i++) preload(i, 32'h1000 + i);
        preload(0, 11); preload(1, 22); preload(2, 33); preload(3, 44);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_copy();
        int  lat;
        wr_t e, o;
        logic [DW-1:0] ref_v [4];
        ref_v = '{32'd11, 32'd22, 32'd33, 32'd44};
        model_xfer(1'b0, 0, 16, 4, '0);
        kick(1'b0, 0, 16, 4, '0);
        wait_done(40, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL copy_latency: got %0d cycles, required 9", lat);
        end
        checks++;
        if (words_done !== 9'd4 || busy !== 1'b0 || wr_en_mem !== 1'b0 ||
            add_mem !== '0 || wrd_mem !== '0) begin
            errors++;
            $display("FAIL copy_done_cycle: got wd=%0d busy=%b we=%b addr=%h data=%h, required wd=4 and rest zero",
                     words_done, busy, wr_en_mem, add_mem, wrd_mem);
        end
        tick();
        checks++;
        if (done !== 1'b0 || words_done !== 9'd4) begin
            errors++;
            $display("FAIL copy_done_pulse: got done=%b wd=%0d after pulse, required done=0 wd=4", done, words_done);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                errors++;
                $display("FAIL copy_writes: %0d writes left unmatched, %0d expected left", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL copy_writes: got addr=%h data=%h, required addr=%h data=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16 + i] !== ref_v[i]) begin
                errors++;
                $display("FAIL copy_mem[%0d]: got %0d, required %0d", 16 + i, mem[16 + i], ref_v[i]);
            end
        end
    endtask

    task automatic test_fill();
        int  lat;
        wr_t e, o;
        model_xfer(1'b1, 0, 100, 3, 32'hDEADBEEF);
        kick(1'b1, 0, 100, 3, 32'hDEADBEEF);
        wait_done(20, lat);
        checks++;
        if (lat !== 4 || words_done !== 9'd3) begin
            errors++;
            $display("FAIL fill_latency: got %0d cycles wd=%0d, required 4 cycles wd=3", lat, words_done);
        end
        tick();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                errors++;
                $display("FAIL fill_writes: %0d writes left unmatched, %0d expected left", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL fill_writes: got addr=%h data=%h, required addr=%h data=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        checks++;
        if (mem[100] !== 32'hDEADBEEF || mem[102] !== 32'hDEADBEEF || mem[103] !== 32'h1000 + 103) begin
            errors++;
            $display("FAIL fill_mem: got m100=%h m102=%h m103=%h, required deadbeef deadbeef %h",
                     mem[100], mem[102], mem[103], 32'h1000 + 103);
        end
    endtask

    task automatic test_len_zero();
        int lat;
        kick(1'b0, 5, 60, 0, '0);
        wait_done(10, lat);
        checks++;
        if (lat !== 1 || words_done !== '0) begin
            errors++;
            $display("FAIL len0_done: got %0d cycles wd=%0d, required 1 cycle wd=0", lat, words_done);
        end
        tick();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL len0_no_write: got %0d writes, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_overlap();
        int  lat;
        wr_t e, o;
        preload(0, 1); preload(1, 2); preload(2, 3);
        model_xfer(1'b0, 0, 1, 2, '0);
        kick(1'b0, 0, 1, 2, '0);
        wait_done(20, lat);
        tick();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                errors++;
                $display("FAIL overlap_writes: %0d writes left unmatched, %0d expected left", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL overlap_writes: got addr=%h data=%h, required addr=%h data=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        checks++;
        if (mem[0] !== 32'd1 || mem[1] !== 32'd1 || mem[2] !== 32'd1) begin
            errors++;
            $display("FAIL overlap_mem: got %0d %0d %0d, required 1 1 1", mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_back_to_back();
        int  lat;
        int  pre;
        wr_t e, o;
        model_xfer(1'b0, 16, 200, 3, '0);
        kick(1'b0, 16, 200, 3, '0);
        pre = 0;
        repeat (2) begin
            tick();
            pre++;
        end
        src_addr = 8; dst_addr = 210; len = 9'd1; mode = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(30, lat);
        checks++;
        if (lat < 0 || pre + lat !== 7 || words_done !== 9'd3) begin
            errors++;
            $display("FAIL busy_start_latency: got %0d cycles wd=%0d, required 7 cycles wd=3", pre + lat, words_done);
        end
        tick();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                errors++;
                $display("FAIL busy_start_writes: %0d writes left unmatched, %0d expected left", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL busy_start_writes: got addr=%h data=%h, required addr=%h data=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit  reached;
        bit  seen_done;
        wr_t e, o;
        model_xfer(1'b0, 0, 50, 2, '0);
        kick(1'b0, 0, 50, 5, '0);
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (obs_q.size() == 2) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midrst_reach: got %0d writes before timeout, required 2", obs_q.size());
        end
        @(posedge clk);
        tick();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        checks++;
        if (wr_en_mem !== 1'b0) begin
            errors++;
            $display("FAIL midrst_we: got wr_en_mem=%b during reset, required 0", wr_en_mem);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || words_done !== '0) begin
            errors++;
            $display("FAIL midrst_busy: got busy=%b wd=%0d after reset, required 0 0", busy, words_done);
        end
        repeat (6) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL midrst_quiet: got done/busy activity after reset, required none");
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                errors++;
                $display("FAIL midrst_writes: %0d writes left unmatched, %0d expected left", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL midrst_writes: got addr=%h data=%h, required addr=%h data=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
        for (int i = 50; i < 55; i++) begin
            checks++;
            if (mem[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL midrst_mem[%0d]: got %h, required %h", i, mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int  lat;
        wr_t e, o;
        model_xfer(1'b1, 0, 32'hFFFF_FFFF, 2, 32'hA5A5_0001);
        kick(1'b1, 0, 32'hFFFF_FFFF, 2, 32'hA5A5_0001);
        wait_done(20, lat);
        checks++;
        if (lat !== 3 || words_done !== 9'd2) begin
            errors++;
            $display("FAIL wrap_latency: got %0d cycles wd=%0d, required 3 cycles wd=2", lat, words_done);
        end
        tick();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_writes: %0d writes left unmatched, %0d expected left", obs_q.size(), exp_q.size());
                exp_q.delete(); obs_q.delete();
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL wrap_writes: got addr=%h data=%h, required addr=%h data=%h", o.a, o.d, e.a, e.d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_len_zero();
        test_overlap();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
